// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - vector load/store sequencer, one element per Clk1 cycle
// Optional VEC_MEM_STRIDE_EN adds a Stride input for strided element addressing.
module vec_mem_seq #(
  parameter int ELEMS = 16,
  parameter int DW    = 16,
  parameter int AW    = 16
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                Start,
  input  logic                IsStore,
  input  logic [AW-1:0]       BaseAddr,
  input  logic [ELEMS*DW-1:0] VecIn,
`ifdef VEC_MEM_STRIDE_EN
  input  logic [AW-1:0]       Stride,
`endif
  input  logic [DW-1:0]       MemDataIn,
  output logic [AW-1:0]       MemAddr,
  output logic                MemRD,
  output logic                MemWR,
  output logic [DW-1:0]       MemDataOut,
  output logic [ELEMS*DW-1:0] VecOut,
  output logic                VecWR,
  output logic                Busy,
  output logic                Done
);
  localparam int IW = $clog2(ELEMS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ELEMS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LOAD_LAST, STORE, FINISH} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       idx_nxt, cap_idx;
  logic [ELEMS*DW-1:0] snap_q, snap_d;
  logic [ELEMS*DW-1:0] vec_out_q, vec_out_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [AW-1:0]       step;
  logic [DW-1:0]       mem_data_out_q, mem_data_out_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                vec_wr_q, vec_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef VEC_MEM_STRIDE_EN
  logic [AW-1:0]       stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = AW'(1);
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snap_d         = snap_q;
    vec_out_d      = vec_out_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_d       = 1'b0;
    mem_wr_d       = 1'b0;
    mem_data_out_d = '0;
    vec_wr_d       = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
`ifdef VEC_MEM_STRIDE_EN
    stride_d       = stride_q;
`endif
    idx_nxt = idx_q + IW'(1);
    // Read data trails its address by one cycle, so the slot written is one behind idx_q
    cap_idx = (state_q == LOAD_LAST) ? idx_q : idx_q - IW'(1);

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d        = IsStore ? STORE : LOAD;
          idx_d          = '0;
          snap_d         = VecIn;
          mem_addr_d     = BaseAddr;
          mem_rd_d       = !IsStore;
          mem_wr_d       = IsStore;
          mem_data_out_d = IsStore ? VecIn[DW-1:0] : '0;
          busy_d         = 1'b1;
`ifdef VEC_MEM_STRIDE_EN
          stride_d       = Stride;
`endif
        end
      end
      LOAD: begin
        if (idx_q != '0) vec_out_d[int'(cap_idx)*DW +: DW] = MemDataIn;
        if (idx_q == LAST_IDX) begin
          state_d = LOAD_LAST;
        end else begin
          idx_d      = idx_nxt;
          mem_addr_d = mem_addr_q + step;
          mem_rd_d   = 1'b1;
        end
      end
      LOAD_LAST: begin
        vec_out_d[int'(cap_idx)*DW +: DW] = MemDataIn;
        state_d  = FINISH;
        done_d   = 1'b1;
        vec_wr_d = 1'b1;
      end
      STORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          idx_d          = idx_nxt;
          mem_addr_d     = mem_addr_q + step;
          mem_wr_d       = 1'b1;
          mem_data_out_d = snap_q[int'(idx_nxt)*DW +: DW];
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      snap_q         <= '0;
      vec_out_q      <= '0;
      mem_addr_q     <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_data_out_q <= '0;
      vec_wr_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef VEC_MEM_STRIDE_EN
      stride_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      vec_out_q      <= vec_out_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      mem_data_out_q <= mem_data_out_d;
      vec_wr_q       <= vec_wr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef VEC_MEM_STRIDE_EN
      stride_q       <= stride_d;
`endif
    end
  end

  assign MemAddr    = mem_addr_q;
  assign MemRD      = mem_rd_q;
  assign MemWR      = mem_wr_q;
  assign MemDataOut = mem_data_out_q;
  assign VecOut     = vec_out_q;
  assign VecWR      = vec_wr_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - randomized self-checking bench for vec_mem_seq
// Builds with or without VEC_MEM_STRIDE_EN.
module tb_vec_mem_seq;
  logic         Clk1 = 1'b0;
  logic         Reset, Start, IsStore;
  logic [15:0]  BaseAddr;
  logic [255:0] VecIn;
  logic [15:0]  MemDataIn = 16'h0000;
  logic [15:0]  MemAddr, MemDataOut;
  logic         MemRD, MemWR, VecWR, Busy, Done;
  logic [255:0] VecOut;
`ifdef VEC_MEM_STRIDE_EN
  logic [15:0]  Stride;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [15:0]  key = 16'hA5A5;
  logic [255:0] last_vec = '0;

  vec_mem_seq dut (
    .Clk1(Clk1), .Reset(Reset), .Start(Start), .IsStore(IsStore),
    .BaseAddr(BaseAddr), .VecIn(VecIn),
`ifdef VEC_MEM_STRIDE_EN
    .Stride(Stride),
`endif
    .MemDataIn(MemDataIn), .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR),
    .MemDataOut(MemDataOut), .VecOut(VecOut), .VecWR(VecWR), .Busy(Busy), .Done(Done)
  );

  always #5 Clk1 = ~Clk1;

  // Memory: mem[a] = a ^ key, data valid the cycle after the address
  always @(posedge Clk1) MemDataIn <= MemRD ? (MemAddr ^ key) : 16'hDEAD;

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  // Starts a transfer in the current cycle (cycle 0) and checks through the first IDLE cycle.
  task automatic run_xfer(input bit st, input logic [15:0] base, input logic [15:0] stride,
                          input logic [255:0] vec, input int junk_a, input int junk_b,
                          input int rst_cyc, input bit chg_vec);
    int           last;
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    logic [4:0]   exp_ctl, got_ctl;
    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = 16'(base + 16'(i) * stride) ^ key;
    IsStore  = st;
    BaseAddr = base;
    VecIn    = vec;
`ifdef VEC_MEM_STRIDE_EN
    Stride   = stride;
`endif
    Start    = 1'b1;
    @(posedge Clk1); #1;
    Start = 1'b0;
    last  = st ? 17 : 18;
    for (int c = 1; c <= last + 1; c++) begin
      if (c == rst_cyc) begin
        Reset = 1'b1;
        @(posedge Clk1); #1;
        Reset    = 1'b0;
        last_vec = '0;
        for (int k = 0; k < 2; k++) begin
          checks++;
          if ({MemAddr, MemRD, MemWR, MemDataOut, VecWR, Busy, Done} !== 37'd0 || VecOut !== 256'd0) begin
            errors++;
            $display("FAIL reset_abort k=%0d: addr=%h rd=%b wr=%b wdata=%h vecwr=%b busy=%b done=%b vecout=%h, required all zero",
                     k, MemAddr, MemRD, MemWR, MemDataOut, VecWR, Busy, Done, VecOut);
          end
          if (k == 0) begin @(posedge Clk1); #1; end
        end
        return;
      end
      got_ctl = {MemRD, MemWR, Busy, Done, VecWR};
      if (c <= 16)        exp_ctl = st ? 5'b01100 : 5'b10100;
      else if (c < last)  exp_ctl = 5'b00100;
      else if (c == last) exp_ctl = st ? 5'b00110 : 5'b00111;
      else                exp_ctl = 5'b00000;
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl cycle %0d base=%h: {rd,wr,busy,done,vecwr}=%b required %b", c, base, got_ctl, exp_ctl);
      end
      if (c <= 16) begin
        ea = 16'(base + 16'(c - 1) * stride);
        checks++;
        if (MemAddr !== ea) begin
          errors++;
          $display("FAIL addr cycle %0d: MemAddr=%h required %h", c, MemAddr, ea);
        end
        if (st) begin
          checks++;
          if (MemDataOut !== vec[16*(c-1) +: 16]) begin
            errors++;
            $display("FAIL wdata cycle %0d: MemDataOut=%h required %h", c, MemDataOut, vec[16*(c-1) +: 16]);
          end
        end
      end
      if (c == last) begin
        if (!st) last_vec = exp_vec;
        checks++;
        if (VecOut !== last_vec) begin
          errors++;
          $display("FAIL vecout cycle %0d: VecOut=%h required %h", c, VecOut, last_vec);
        end
      end
      if (c == junk_a || c == junk_b) begin
        Start    = 1'b1;
        IsStore  = 1'($urandom);
        BaseAddr = 16'($urandom);
      end
      if (chg_vec && c == 2) VecIn = ~vec;
      if (c <= last) begin
        @(posedge Clk1); #1;
        Start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; IsStore = 1'b0; BaseAddr = '0; VecIn = '0;
`ifdef VEC_MEM_STRIDE_EN
    Stride = 16'd1;
`endif
    repeat (3) @(posedge Clk1);
    #1;
    checks++;
    if ({MemAddr, MemRD, MemWR, MemDataOut, VecWR, Busy, Done} !== 37'd0 || VecOut !== 256'd0) begin
      errors++;
      $display("FAIL reset_state: addr=%h rd=%b wr=%b wdata=%h vecwr=%b busy=%b done=%b, required all zero",
               MemAddr, MemRD, MemWR, MemDataOut, VecWR, Busy, Done);
    end
    Reset = 1'b0;
    @(posedge Clk1); #1;
    checks++;
    if ({MemRD, MemWR, Busy, Done, VecWR} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ctl=%b required 00000", {MemRD, MemWR, Busy, Done, VecWR});
    end
  endtask

  task automatic test_load();
    key = 16'hA5A5;
    run_xfer(1'b0, 16'h0010, 16'd1, rand_vec(), 0, 0, 0, 1'b0);
  endtask

  task automatic test_store();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'h1000 + 16'(i);
    run_xfer(1'b1, 16'h0200, 16'd1, v, 0, 0, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_xfer(1'b0, 16'hFFFA, 16'd1, rand_vec(), 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b0, 16'h0300, 16'd1, rand_vec(), 5, 18, 0, 1'b0);
    run_xfer(1'b0, 16'h0400, 16'd1, rand_vec(), 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_xfer(1'b1, 16'h0500, 16'd1, rand_vec(), 0, 0, 8, 1'b0);
    key = 16'h3C3C;
    run_xfer(1'b0, 16'h0600, 16'd1, rand_vec(), 0, 0, 0, 1'b0);
  endtask

  task automatic test_stride();
`ifdef VEC_MEM_STRIDE_EN
    key = 16'h5A5A;
    run_xfer(1'b0, 16'h0100, 16'h0004, rand_vec(), 0, 0, 0, 1'b0);
    run_xfer(1'b0, 16'h0100, 16'h0000, rand_vec(), 0, 0, 0, 1'b0);
    run_xfer(1'b1, 16'hFFF0, 16'h0003, rand_vec(), 0, 0, 0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [15:0] s;
    for (int n = 0; n < 8; n++) begin
      key = 16'($urandom);
`ifdef VEC_MEM_STRIDE_EN
      s = (n == 3) ? 16'd0 : 16'($urandom);
`else
      s = 16'd1;
`endif
      run_xfer(1'($urandom), 16'($urandom), s, rand_vec(), 0, 0, 0, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_stride();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
